// File: rtl/ps2_piano_input.sv
// PS/2 keyboard receiver and set-2 scan-code decoder that maintains the piano
// pressed[] vector and emits one-cycle note press/release events.
module ps2_piano_input #(
    parameter int octaves = 2,
    parameter int timeout = 50000,
    parameter int toBits  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2Clk,
    input  logic                  ps2Data,
    input  logic                  clear,
    output logic [12*octaves-1:0] pressed,
    output logic                  keyValid,
    output logic [4:0]            keyIndex,
    output logic                  keyDown,
    output logic                  frameError
);

    localparam int                NOTES   = 12 * octaves;
    localparam logic [toBits-1:0] TO_LAST = toBits'(timeout - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_SHIFT = 2'd1;
    localparam logic [1:0] RX_CHECK = 2'd2;

    localparam logic [1:0] DEC_IDLE   = 2'd0;
    localparam logic [1:0] DEC_BRK    = 2'd1;
    localparam logic [1:0] DEC_EXT    = 2'd2;
    localparam logic [1:0] DEC_EXTBRK = 2'd3;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Returns {hit, note index} for the set-2 piano key map.
    function automatic logic [5:0] key_lookup(input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h1A: r = {1'b1, 5'd0};
            8'h1B: r = {1'b1, 5'd1};
            8'h22: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h21: r = {1'b1, 5'd4};
            8'h2A: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h32: r = {1'b1, 5'd7};
            8'h33: r = {1'b1, 5'd8};
            8'h31: r = {1'b1, 5'd9};
            8'h3B: r = {1'b1, 5'd10};
            8'h3A: r = {1'b1, 5'd11};
            8'h15: r = {1'b1, 5'd12};
            8'h1E: r = {1'b1, 5'd13};
            8'h1D: r = {1'b1, 5'd14};
            8'h26: r = {1'b1, 5'd15};
            8'h24: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h2E: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h36: r = {1'b1, 5'd20};
            8'h35: r = {1'b1, 5'd21};
            8'h3D: r = {1'b1, 5'd22};
            8'h3C: r = {1'b1, 5'd23};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Synchroniser and edge detection
    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        data_sync_q, data_sync_d;
    logic              clk_prev_q, clk_prev_d;
    logic              fall;
    logic              rx_bit;

    // Receiver
    logic [1:0]        rx_state_q, rx_state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic [toBits-1:0] to_cnt_q, to_cnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic [7:0]        byte_q, byte_d;
    logic              frame_error_q, frame_error_d;

    // Decoder and key state
    logic [1:0]        dec_state_q, dec_state_d;
    logic [23:0]       pressed_q, pressed_d;
    logic              key_valid_q, key_valid_d;
    logic [4:0]        key_index_q, key_index_d;
    logic              key_down_q, key_down_d;

    logic [5:0]        map;
    logic              map_hit;
    logic [4:0]        map_idx;
    logic              do_event;
    logic              ev_down;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2Clk};
        data_sync_d = {data_sync_q[0], ps2Data};
        clk_prev_d  = clk_sync_q[1];
        fall        = clk_prev_q & ~clk_sync_q[1];
        rx_bit      = data_sync_q[1];
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        rx_state_d    = rx_state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        to_cnt_d      = to_cnt_q;
        byte_valid_d  = 1'b0;
        byte_d        = byte_q;
        frame_error_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                to_cnt_d = '0;
                if (fall && !rx_bit) begin
                    rx_state_d = RX_SHIFT;
                    bit_cnt_d  = 4'd0;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    // Bits arrive LSB first; after ten edges shift_q = {stop, parity, data}.
                    shift_d  = {rx_bit, shift_q[9:1]};
                    to_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        rx_state_d = RX_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    frame_error_d = 1'b1;
                    rx_state_d    = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RX_CHECK: begin
                rx_state_d = RX_IDLE;
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q[7:0];
                end else begin
                    frame_error_d = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        map     = key_lookup(byte_q);
        map_idx = map[4:0];
        map_hit = map[5] && (map_idx < 5'(NOTES));
    end

    always_comb begin
        dec_state_d = dec_state_q;
        pressed_d   = pressed_q;
        key_valid_d = 1'b0;
        key_index_d = key_index_q;
        key_down_d  = key_down_q;
        do_event    = 1'b0;
        ev_down     = 1'b0;

        // A bad frame drops any pending E0/F0 prefix.
        if (frame_error_q) begin
            dec_state_d = DEC_IDLE;
        end else if (byte_valid_q) begin
            case (dec_state_q)
                DEC_IDLE: begin
                    if (byte_q == CODE_EXT) begin
                        dec_state_d = DEC_EXT;
                    end else if (byte_q == CODE_BRK) begin
                        dec_state_d = DEC_BRK;
                    end else if (map_hit) begin
                        do_event = 1'b1;
                        ev_down  = 1'b1;
                    end
                end
                DEC_BRK: begin
                    dec_state_d = DEC_IDLE;
                    do_event    = map_hit;
                end
                DEC_EXT:    dec_state_d = (byte_q == CODE_BRK) ? DEC_EXTBRK : DEC_IDLE;
                DEC_EXTBRK: dec_state_d = DEC_IDLE;
                default:    dec_state_d = DEC_IDLE;
            endcase
        end

        if (clear) begin
            pressed_d = '0;
        end else if (do_event && (pressed_q[map_idx] != ev_down)) begin
            pressed_d[map_idx] = ev_down;
            key_valid_d        = 1'b1;
            key_index_d        = map_idx;
            key_down_d         = ev_down;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchronisers reset to the idle-high line level so reset release never fakes a falling edge.
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            clk_prev_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            to_cnt_q      <= '0;
            byte_valid_q  <= 1'b0;
            byte_q        <= 8'd0;
            frame_error_q <= 1'b0;
            dec_state_q   <= DEC_IDLE;
            pressed_q     <= 24'd0;
            key_valid_q   <= 1'b0;
            key_index_q   <= 5'd0;
            key_down_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            rx_state_q    <= rx_state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            to_cnt_q      <= to_cnt_d;
            byte_valid_q  <= byte_valid_d;
            byte_q        <= byte_d;
            frame_error_q <= frame_error_d;
            dec_state_q   <= dec_state_d;
            pressed_q     <= pressed_d;
            key_valid_q   <= key_valid_d;
            key_index_q   <= key_index_d;
            key_down_q    <= key_down_d;
        end
    end

    assign pressed    = pressed_q[NOTES-1:0];
    assign keyValid   = key_valid_q;
    assign keyIndex   = key_index_q;
    assign keyDown    = key_down_q;
    assign frameError = frame_error_q;

endmodule

// File: tb/tb_ps2_piano_input.sv
// Self-checking bench: directed scenarios plus random PS/2 traffic compared
// against a byte-level key model, on a 2-octave and a 1-octave instance.
module tb_ps2_piano_input;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2Clk;
    logic        ps2Data;
    logic        clear;

    logic [23:0] pressed2;
    logic        kv2, kd2, fe2;
    logic [4:0]  ki2;
    logic [11:0] pressed1;
    logic        kv1, kd1, fe1;
    logic [4:0]  ki1;

    always #5 clk = ~clk;

    ps2_piano_input #(.octaves(2), .timeout(TO), .toBits(8)) dut2 (
        .clk(clk), .rst(rst), .ps2Clk(ps2Clk), .ps2Data(ps2Data), .clear(clear),
        .pressed(pressed2), .keyValid(kv2), .keyIndex(ki2), .keyDown(kd2), .frameError(fe2)
    );

    ps2_piano_input #(.octaves(1), .timeout(TO), .toBits(8)) dut1 (
        .clk(clk), .rst(rst), .ps2Clk(ps2Clk), .ps2Data(ps2Data), .clear(clear),
        .pressed(pressed1), .keyValid(kv1), .keyIndex(ki1), .keyDown(kd1), .frameError(fe1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  keys [24] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                               8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
                               8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C};
    logic [23:0] mp [2];
    bit          m_e0, m_f0;
    logic [5:0]  last_ev [2];
    int          fe_exp [2];
    int          fe_obs [2];
    logic [5:0]  exp2[$], exp1[$], obs2[$], obs1[$];

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 24; i++) if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mp[0] = '0; mp[1] = '0;
        m_e0 = 0; m_f0 = 0;
        last_ev[0] = '0; last_ev[1] = '0;
        exp2.delete(); exp1.delete(); obs2.delete(); obs1.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit drop);
        int  n;
        bit  down;
        int  limit;
        logic [5:0] ev;
        n = note_of(b);
        if (b == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
        else if (b == 8'hF0 && !m_f0) m_f0 = 1;
        else begin
            down = !m_f0;
            if (!m_e0 && n >= 0 && !drop) begin
                for (int k = 0; k < 2; k++) begin
                    limit = (k == 0) ? 24 : 12;
                    if (n < limit && mp[k][n] != down) begin
                        mp[k][n] = down;
                        ev = {down, 5'(n)};
                        last_ev[k] = ev;
                        if (k == 0) exp2.push_back(ev); else exp1.push_back(ev);
                    end
                end
            end
            m_e0 = 0; m_f0 = 0;
        end
        if (drop) begin
            mp[0] = '0; mp[1] = '0;
        end
    endtask

    task automatic model_frame_error();
        m_e0 = 0; m_f0 = 0;
        fe_exp[0]++; fe_exp[1]++;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (kv2) obs2.push_back({kd2, ki2});
            if (kv1) obs1.push_back({kd1, ki1});
            if (fe2) fe_obs[0]++;
            if (fe1) fe_obs[1]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2Data = f[i];
            repeat (half) @(negedge clk);
            ps2Clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2Clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
        send_bits(make_frame(b, bad_par, bad_stop), 11, half);
        if (bad_par || bad_stop) model_frame_error();
        else model_byte(b, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic end_check();
        logic [5:0] o, e;
        check("pressed2", 32'(pressed2), 32'(mp[0]));
        check("pressed1", 32'(pressed1), 32'(mp[1][11:0]));
        check("ev_count2", 32'(obs2.size()), 32'(exp2.size()));
        check("ev_count1", 32'(obs1.size()), 32'(exp1.size()));
        while (obs2.size() > 0 && exp2.size() > 0) begin
            o = obs2.pop_front(); e = exp2.pop_front();
            check("event2", 32'(o), 32'(e));
        end
        while (obs1.size() > 0 && exp1.size() > 0) begin
            o = obs1.pop_front(); e = exp1.pop_front();
            check("event1", 32'(o), 32'(e));
        end
        obs2.delete(); exp2.delete(); obs1.delete(); exp1.delete();
        check("fe_count2", 32'(fe_obs[0]), 32'(fe_exp[0]));
        check("fe_count1", 32'(fe_obs[1]), 32'(fe_exp[1]));
        check("idx_hold2", 32'({kd2, ki2}), 32'(last_ev[0]));
        check("idx_hold1", 32'({kd1, ki1}), 32'(last_ev[1]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pressed2"}, 32'(pressed2), 32'd0);
        check({tag, "_pressed1"}, 32'(pressed1), 32'd0);
        check({tag, "_kv"}, 32'({kv2, kv1}), 32'd0);
        check({tag, "_ki"}, 32'({ki2, ki1}), 32'd0);
        check({tag, "_kd"}, 32'({kd2, kd1}), 32'd0);
        check({tag, "_fe"}, 32'({fe2, fe1}), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cat;
        int          half;
        logic [7:0]  b;
        logic [10:0] f;

        fe_exp[0] = 0; fe_exp[1] = 0;
        fe_obs[0] = 0; fe_obs[1] = 0;
        model_reset();
        rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; clear = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 0x1A with exact output latency after the stop-bit falling edge
        f = make_frame(8'h1A, 0, 0);
        send_bits(f, 10, 4);
        @(negedge clk) ps2Data = 1'b1;
        repeat (4) @(negedge clk);
        ps2Clk = 1'b0;
        model_byte(8'h1A, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("lat_early_kv", 32'(kv2), 32'd0);
        check("lat_early_p0", 32'(pressed2[0]), 32'd0);
        @(posedge clk);
        #1;
        check("lat_kv", 32'(kv2), 32'd1);
        check("lat_p0", 32'(pressed2[0]), 32'd1);
        check("lat_ki", 32'(ki2), 32'd0);
        check("lat_kd", 32'(kd2), 32'd1);
        @(posedge clk);
        #1;
        check("lat_pulse_end", 32'(kv2), 32'd0);
        repeat (2) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (6) @(negedge clk);
        end_check();

        // Typematic repeat then release
        send_frame(8'h1A, 0, 0, 5); end_check();
        send_frame(8'hF0, 0, 0, 5);
        send_frame(8'h1A, 0, 0, 5); end_check();

        // Parity error, then bad-parity F0 dropped so 0x15 is a press
        send_frame(8'h15, 1, 0, 4); end_check();
        send_frame(8'hF0, 1, 0, 4);
        send_frame(8'h15, 0, 0, 4); end_check();
        send_frame(8'hF0, 0, 0, 4);
        send_frame(8'h15, 0, 0, 4); end_check();

        // Timeout on a partial frame, then a valid 0x3C
        send_bits(make_frame(8'h3C, 0, 0), 4, 4);
        repeat (TO + 10) @(negedge clk);
        model_frame_error();
        end_check();
        send_frame(8'h3C, 0, 0, 4); end_check();
        check("t4_p23", 32'(pressed2[23]), 32'd1);

        // Extended codes ignored; octave-1 key ignored on the 1-octave instance
        send_frame(8'hE0, 0, 0, 3);
        send_frame(8'h1A, 0, 0, 3); end_check();
        send_frame(8'hE0, 0, 0, 3);
        send_frame(8'hF0, 0, 0, 3);
        send_frame(8'h1A, 0, 0, 3); end_check();
        send_frame(8'h15, 0, 0, 3); end_check();

        // clear coinciding with the decode of 0x3A
        send_frame(8'h1A, 0, 0, 4);
        send_frame(8'h23, 0, 0, 4); end_check();
        send_bits(make_frame(8'h3A, 0, 0), 10, 4);
        @(negedge clk) ps2Data = 1'b1;
        repeat (4) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        model_byte(8'h3A, 1'b1);
        check("clear_now", 32'(pressed2), 32'd0);
        repeat (2) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (6) @(negedge clk);
        end_check();

        // Random traffic
        for (int s = 0; s < 120; s++) begin
            half = int'($urandom_range(3, 8));
            cat  = int'($urandom_range(0, 99));
            if (cat < 55) begin
                b = keys[$urandom_range(0, 23)];
                send_frame(b, 0, 0, half);
            end else if (cat < 68) send_frame(8'hF0, 0, 0, half);
            else if (cat < 72) send_frame(8'hE0, 0, 0, half);
            else if (cat < 77) send_frame(8'($urandom_range(0, 255)), 0, 0, half);
            else if (cat < 85) send_frame(8'($urandom_range(0, 255)), 1, 0, half);
            else if (cat < 90) send_frame(8'($urandom_range(0, 255)), 0, 1, half);
            else begin
                @(negedge clk) clear = 1'b1;
                @(negedge clk) clear = 1'b0;
                mp[0] = '0; mp[1] = '0;
                repeat (3) @(negedge clk);
            end
            end_check();
        end

        // Reset in the middle of a frame, with keys held
        send_frame(8'h1A, 0, 0, 4);
        send_frame(8'h3B, 0, 0, 4); end_check();
        send_bits(make_frame(8'h22, 0, 0), 5, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_mid");
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_after");
        send_frame(8'h3C, 0, 0, 4); end_check();
        check("rst_p23", 32'(pressed2[23]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
